trigger_conditioner: RTL and testbench

Conditions a raw, bouncy pushbutton (or any slow asynchronous level) into clean single-cycle trigger pulses for the 3-bit up counter's `T` input. It synchronizes the input, debounces it, and emits one pulse per debounced press. With auto-repeat enabled, it also emits repeat pulses at a fixed rate while the button is held. It sits directly upstream of the counter, and its `trig` output wires straight to the counter's `T`.

---
 rtl/trigger_conditioner.sv | 159 +++++++++++++++
 tb/tb_trigger_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_conditioner.sv
// Turns a bouncy asynchronous pushbutton into clean one-cycle trigger pulses,
// with optional auto-repeat while the debounced button stays held.
module trigger_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic trig,
    output logic btn_level,
    output logic repeating
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HELD   = 2'b01,
        ST_REPEAT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic [CNT_W-1:0] deb_cnt_next_s;
    logic             level_r;
    logic             level_next_s;
    logic             level_rise_s;
    logic             level_fall_s;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_next_s;
    logic             trig_r;
    logic             trig_next_s;
    logic             repeating_r;

    // Two-flop synchronizer for the raw asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: any single cycle of agreement restarts the mismatch count.
    always_comb begin
        deb_cnt_next_s = CNT_ZERO;
        level_next_s   = level_r;
        level_rise_s   = 1'b0;
        level_fall_s   = 1'b0;
        if (sync2_r != level_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                level_next_s   = sync2_r;
                deb_cnt_next_s = CNT_ZERO;
                level_rise_s   = sync2_r;
                level_fall_s   = ~sync2_r;
            end else begin
                deb_cnt_next_s = deb_cnt_r + CNT_ONE;
            end
        end else begin
            deb_cnt_next_s = CNT_ZERO;
        end
    end

    // Debounce counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_r <= CNT_ZERO;
            level_r   <= 1'b0;
        end else begin
            deb_cnt_r <= deb_cnt_next_s;
            level_r   <= level_next_s;
        end
    end

    // Press/repeat FSM; a release wins over any pulse due on the same edge.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        trig_next_s  = 1'b0;
        if (level_fall_s) begin
            state_next_s = ST_IDLE;
            timer_next_s = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timer_next_s = CNT_ZERO;
                    if (level_rise_s) begin
                        trig_next_s  = 1'b1;
                        state_next_s = ST_HELD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (repeat_en) begin
                        if (timer_r == DELAY_LAST) begin
                            trig_next_s  = 1'b1;
                            timer_next_s = CNT_ZERO;
                            state_next_s = ST_REPEAT;
                        end else begin
                            timer_next_s = timer_r + CNT_ONE;
                        end
                    end else begin
                        timer_next_s = CNT_ZERO;
                    end
                end
                ST_REPEAT: begin
                    if (!repeat_en) begin
                        timer_next_s = CNT_ZERO;
                        state_next_s = ST_HELD;
                    end else if (timer_r == PERIOD_LAST) begin
                        trig_next_s  = 1'b1;
                        timer_next_s = CNT_ZERO;
                    end else begin
                        timer_next_s = timer_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    timer_next_s = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state, repeat timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= CNT_ZERO;
            trig_r      <= 1'b0;
            repeating_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            timer_r     <= timer_next_s;
            trig_r      <= trig_next_s;
            repeating_r <= (state_next_s == ST_REPEAT);
        end
    end

    assign trig      = trig_r;
    assign btn_level = level_r;
    assign repeating = repeating_r;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: a cycle table for the clean press,
// then hand-written sequences for bounce, repeat, release priority and reset.
module tb_trigger_conditioner;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic repeat_en;
    logic trig;
    logic btn_level;
    logic repeating;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;
    int a, p, b, d, u, r, pulses;
    logic pat [5];

    typedef struct {
        logic rst;
        logic btn;
        logic ren;
        logic e_trig;
        logic e_level;
        logic e_rep;
    } vec_t;

    vec_t vecs [20];

    trigger_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .repeat_en(repeat_en),
        .trig     (trig),
        .btn_level(btn_level),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    // Inputs set after tick() are sampled on the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %b want %b", name, edge_n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %0d want %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic et, input logic el, input logic er);
        check({tag, ".trig"}, trig, et);
        check({tag, ".level"}, btn_level, el);
        check({tag, ".repeating"}, repeating, er);
    endtask

    task automatic release_and_settle(input string tag);
        btn_in = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
        end
        check_all(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;

        // Clean press: reset on edges 1-2, btn first sampled at edge 10,
        // level and trig rise at 10+1+D = 15.
        for (int i = 0; i < 20; i++) begin
            vecs[i].rst     = ((i + 1) <= 2);
            vecs[i].btn     = ((i + 1) >= 10);
            vecs[i].ren     = 1'b0;
            vecs[i].e_trig  = ((i + 1) == 15);
            vecs[i].e_level = ((i + 1) >= 15);
            vecs[i].e_rep   = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            reset     = vecs[i].rst;
            btn_in    = vecs[i].btn;
            repeat_en = vecs[i].ren;
            tick();
            check_all("press", vecs[i].e_trig, vecs[i].e_level, vecs[i].e_rep);
        end
        for (int j = 0; j < 50; j++) begin
            tick();
            check("press_hold.trig", trig, 1'b0);
            check("press_hold.level", btn_level, 1'b1);
        end

        // Release: low first sampled at edge b, level falls at b+5.
        btn_in = 1'b0;
        b = edge_n + 1;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("release.level", btn_level, (edge_n < b + 5));
            check("release.trig", trig, 1'b0);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
        end

        // Bounce 1,0,1,1,0 sampled at b..b+4, final 1 sampled at b+5 -> pulse at b+10.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
        b = edge_n + 1;
        pulses = 0;
        for (int j = 0; j < 30; j++) begin
            btn_in = (j < 5) ? pat[j] : 1'b1;
            tick();
            if (trig) pulses++;
            check("bounce.trig", trig, (edge_n == b + 10));
        end
        check_int("bounce.count", pulses, 1);
        release_and_settle("settle1");

        // Auto-repeat: press pulse at p, repeats at p+8, p+11, p+14, p+17.
        repeat_en = 1'b1;
        btn_in    = 1'b1;
        a = edge_n + 1;
        p = a + D + 1;
        for (int j = 0; j < 23; j++) begin
            tick();
            check_all("repeat", (edge_n == p) || (edge_n >= p + RD && ((edge_n - p - RD) % RP) == 0),
                      (edge_n >= p), (edge_n >= p + RD));
        end

        // Release sampled at p+18 -> level falls at p+23, which is also a repeat slot.
        btn_in = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_all("prio", (edge_n == p + 20), (edge_n < p + 23), (edge_n < p + 23));
        end

        // repeat_en drop after the p2+11 pulse, then raise it again.
        btn_in = 1'b1;
        a = edge_n + 1;
        p = a + D + 1;
        for (int j = 0; j < 17; j++) begin
            tick();
            check_all("drop_pre", (edge_n == p) || (edge_n == p + RD) || (edge_n == p + RD + RP),
                      (edge_n >= p), (edge_n >= p + RD));
        end
        repeat_en = 1'b0;
        d = edge_n + 1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check_all("drop", 1'b0, 1'b1, 1'b0);
        end
        repeat_en = 1'b1;
        u = edge_n + 1;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_all("reraise", (edge_n == u + RD - 1), 1'b1, (edge_n >= u + RD - 1));
        end

        // Reset for one cycle in REPEAT with button held; fresh press pulse at r+6.
        reset = 1'b1;
        tick();
        r = edge_n;
        check_all("rst_mid", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int j = 0; j < 9; j++) begin
            tick();
            check_all("after_rst", (edge_n == r + D + 2), (edge_n >= r + D + 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
